config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/cfg_pkg.sv | 24 ++
 rtl/config_loader_if.sv | 32 +++
 rtl/config_loader.sv | 182 ++++++++++++++++++
 tb/tb_config_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration chain loader: FSM state
// encoding, default geometry and a small arithmetic helper.
package cfg_pkg;

  // Default width of one parallel configuration word.
  localparam int unsigned DEF_DATA_W    = 8;
  // Default number of bits that make up one full chain load.
  localparam int unsigned DEF_CHAIN_LEN = 20;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_WORD = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // Smaller of two unsigned quantities. Used to size the final,
  // possibly partial, word of a load.
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/config_loader_if.sv
// Word-stream handshake between an upstream configuration source and the
// loader.
//
// Handshake: a word transfers on a rising clock edge where in_valid and
// in_ready are both 1. The source holds in_data stable while in_valid is 1
// and must not wait for in_ready before raising in_valid; the loader raises
// in_ready purely from its own state, never from in_valid.
interface config_loader_if
  import cfg_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  // Word source side.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  // Loader side.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/config_loader.sv
// Configuration chain loader. Accepts parallel words over a valid/ready
// handshake and serialises them MSB-first into a downstream shift chain,
// stopping after exactly CHAIN_LEN bits. The chain only shifts while the
// loader is actively serialising, so upstream stalls leave it untouched.
module config_loader
  import cfg_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic            prog_clk,
  input  logic            prog_rst_n,
  input  logic            start,
  input  logic            abort,
  config_loader_if.slave  in_if,
  output logic            prog_in,
  output logic            prog_en,
  output logic            busy,
  output logic            done,
  output state_e          dbg_state
);

  // Bits loaded so far this load; sized so CHAIN_LEN itself is representable.
  localparam int unsigned BC_W = $clog2(CHAIN_LEN + 1);
  // Bits still to shift from the current word; sized to hold DATA_W.
  localparam int unsigned WC_W = $clog2(DATA_W + 1);

  localparam logic [BC_W-1:0] BC_FULL = BC_W'(CHAIN_LEN);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

  // FSM state.
  state_e state_q;
  state_e state_d;

  // Serialising datapath.
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [BC_W-1:0]   bit_cnt_d;
  logic [WC_W-1:0]   word_cnt_q;
  logic [WC_W-1:0]   word_cnt_d;

  // Registered chain drive.
  logic              prog_in_q;
  logic              prog_in_d;
  logic              prog_en_q;
  logic              prog_en_d;

  // Decoded state outputs.
  logic              in_ready_w;
  logic              busy_w;
  logic              done_w;

  // Helper terms.
  logic              handshake;
  logic              last_bit;
  logic [BC_W-1:0]   bit_cnt_inc;
  logic [31:0]       rem_bits;

  assign handshake   = in_if.in_valid && in_ready_w;
  assign last_bit    = (word_cnt_q == WC_ONE);
  // Saturate so the counter can never wrap past a full chain.
  assign bit_cnt_inc = (bit_cnt_q == BC_FULL) ? bit_cnt_q : (bit_cnt_q + BC_W'(1));
  // Bits of the chain not yet loaded; bounds the size of the next word.
  assign rem_bits    = CHAIN_LEN - 32'(bit_cnt_q);

  // State register.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_WAIT_WORD;
          end
        end
        ST_WAIT_WORD: begin
          if (handshake) begin
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            state_d = (bit_cnt_inc == BC_FULL) ? ST_DONE : ST_WAIT_WORD;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State-decoded outputs: ready only while waiting for a word.
  always_comb begin
    in_ready_w = (state_q == ST_WAIT_WORD);
    busy_w     = (state_q != ST_IDLE);
    done_w     = (state_q == ST_DONE);
  end

  // Datapath next values: word capture, shifting and bit accounting.
  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    if (abort) begin
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end
        end
        ST_WAIT_WORD: begin
          if (handshake) begin
            shreg_d    = in_if.in_data;
            // The final word may be only partly used; its low bits are dropped.
            word_cnt_d = WC_W'(min_u(DATA_W, rem_bits));
          end
        end
        ST_SHIFT: begin
          shreg_d    = shreg_q << 1;
          bit_cnt_d  = bit_cnt_inc;
          word_cnt_d = (word_cnt_q == '0) ? word_cnt_q : (word_cnt_q - WC_ONE);
        end
        default: begin
          shreg_d = shreg_q;
        end
      endcase
    end
  end

  // Chain drive is computed from the next state so that the registered
  // prog_en is high exactly during SHIFT cycles and prog_in carries the
  // shift register MSB in those same cycles.
  always_comb begin
    prog_en_d = (state_d == ST_SHIFT);
    prog_in_d = prog_en_d ? shreg_d[DATA_W-1] : 1'b0;
  end

  // Datapath and output registers.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      prog_in_q  <= 1'b0;
      prog_en_q  <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      prog_in_q  <= prog_in_d;
      prog_en_q  <= prog_en_d;
    end
  end

  assign in_if.in_ready = in_ready_w;
  assign busy           = busy_w;
  assign done           = done_w;
  assign prog_in        = prog_in_q;
  assign prog_en        = prog_en_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader with CHAIN_LEN=20, DATA_W=8. A reference bit
// queue built from the words handed over is compared against the serial
// output on every shifting cycle; a modelled 20-stage downstream chain is
// compared against the expected load image after each completed load.
module tb_config_loader;
  import cfg_pkg::*;

  localparam int DW = 8;
  localparam int CL = 20;

  // ---------------- clock / reset ----------------
  logic clk;
  logic prog_rst_n;
  logic start;
  logic abort;
  logic prog_in;
  logic prog_en;
  logic busy;
  logic done;
  state_e dut_state;

  config_loader_if #(.DATA_W(DW)) ifc ();

  config_loader #(.DATA_W(DW), .CHAIN_LEN(CL)) dut (
    .prog_clk   (clk),
    .prog_rst_n (prog_rst_n),
    .start      (start),
    .abort      (abort),
    .in_if      (ifc),
    .prog_in    (prog_in),
    .prog_en    (prog_en),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dut_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];
  bit stream[$];
  int pushed;
  int pe_count   = 0;
  int done_count = 0;
  logic [CL-1:0] chain = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Downstream chain: element 0 sits next to prog_in.
  always @(posedge clk) begin
    if (prog_en) chain <= {chain[CL-2:0], prog_in};
  end

  // Per-cycle compare against the expected bit stream.
  always @(negedge clk) begin
    if (prog_rst_n) begin
      if (prog_en) begin
        pe_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_shift got=prog_en=1 exp=prog_en=0");
        end else begin
          logic [0:0] e;
          e = exp_q.pop_front();
          chk("serial_bit", 32'(prog_in), 32'(e));
        end
      end
      if (done) begin
        done_count++;
        chk("done_without_shift", 32'(prog_en), 32'd0);
      end
      if (ifc.in_ready) begin
        chk("ready_busy", 32'(busy), 32'd1);
        chk("ready_no_shift", 32'(prog_en), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    pushed = 0;
    stream.delete();
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) tick();
    ifc.in_data  = w;
    ifc.in_valid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (ifc.in_ready) begin
        for (int b = DW - 1; b >= 0; b--) begin
          if (pushed < CL) begin
            exp_q.push_back(w[b]);
            stream.push_back(w[b]);
            pushed++;
          end
        end
        ok = 1'b1;
      end
      tick();
    end
    ifc.in_valid = 1'b0;
    if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [CL-1:0] image_from_stream();
    logic [CL-1:0] img;
    img = '0;
    for (int i = 0; i < stream.size() && i < CL; i++) img[CL-1-i] = stream[i];
    return img;
  endfunction

  // Complete load of three words; checks completion properties afterwards.
  task automatic full_load(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input logic [DW-1:0] w2, input int gap, input bit poke,
                           output logic [CL-1:0] img);
    int pb;
    int db;
    bit seen;
    pb = pe_count;
    db = done_count;
    seen = 1'b0;
    start_load();
    send_word(w0, 0);
    if (poke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    send_word(w1, gap);
    send_word(w2, gap);
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      if (done_count - db >= 1) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_after_done", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("done_pulses", 32'(done_count - db), 32'd1);
    chk("prog_en_cycles", 32'(pe_count - pb), 32'd20);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    img = image_from_stream();
    chk("chain_image", 32'(chain), 32'(img));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [CL-1:0] img;
    int pb;
    int db;
    bit hit;
    prog_rst_n   = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    ifc.in_data  = '0;
    ifc.in_valid = 1'b0;
    #3;
    chk("rst_prog_en",  32'(prog_en), 32'd0);
    chk("rst_prog_in",  32'(prog_in), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_done",     32'(done), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_state",    32'(dut_state), 32'(ST_IDLE));
    #9;
    prog_rst_n = 1'b1;
    tick();

    // Back-to-back words.
    full_load(8'hA5, 8'h3C, 8'hF0, 0, 1'b0, img);
    chk("pin_stream_a5", 32'(img), 32'h000A53CF);
    chk("pin_chain_a5",  32'(chain), 32'h000A53CF);

    // Stalls of 5 cycles between words: same stream.
    full_load(8'hA5, 8'h3C, 8'hF0, 5, 1'b0, img);
    chk("pin_chain_stall", 32'(chain), 32'h000A53CF);

    // Start pulsed mid-shift is ignored.
    full_load(8'h5A, 8'hC3, 8'h0F, 3, 1'b1, img);
    chk("pin_chain_poke", 32'(chain), 32'h0005AC30);

    // First-in-deepest ordering.
    full_load(8'hFF, 8'h00, 8'hF0, 1, 1'b0, img);
    chk("pin_chain_ff00", 32'(chain), 32'h000FF00F);
    chk("pin_first_bit_deepest", 32'(chain[CL-1]), 32'd1);
    chk("pin_last_bit_nearest",  32'(chain[0]), 32'd1);

    // Abort after 10 shifted bits.
    pb = pe_count;
    db = done_count;
    start_load();
    send_word(8'h96, 0);
    send_word(8'h69, 0);
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (pe_count - pb >= 10) hit = 1'b1;
      else tick();
    end
    chk("abort_reached_10", 32'(hit), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_prog_en", 32'(prog_en), 32'd0);
    chk("abort_busy",    32'(busy), 32'd0);
    exp_q.delete();
    repeat (4) tick();
    chk("abort_no_done",     32'(done_count - db), 32'd0);
    chk("abort_shift_count", 32'(pe_count - pb), 32'd11);
    full_load(8'h12, 8'h34, 8'h56, 0, 1'b0, img);
    chk("pin_chain_after_abort", 32'(chain), 32'h00012345);

    // Abort beats a simultaneous handshake.
    pb = pe_count;
    start_load();
    ifc.in_data  = 8'hEE;
    ifc.in_valid = 1'b1;
    abort        = 1'b1;
    tick();
    abort        = 1'b0;
    ifc.in_valid = 1'b0;
    chk("abort_hs_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("abort_hs_no_shift", 32'(pe_count - pb), 32'd0);

    // Asynchronous reset mid-shift.
    db = done_count;
    start_load();
    send_word(8'hC7, 0);
    repeat (3) tick();
    #2;
    prog_rst_n = 1'b0;
    #1;
    chk("arst_prog_en",  32'(prog_en), 32'd0);
    chk("arst_prog_in",  32'(prog_in), 32'd0);
    chk("arst_busy",     32'(busy), 32'd0);
    chk("arst_done",     32'(done), 32'd0);
    chk("arst_in_ready", 32'(ifc.in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #1;
    prog_rst_n = 1'b1;
    tick();
    chk("arst_no_done", 32'(done_count - db), 32'd0);
    full_load(8'h81, 8'h7E, 8'hA0, 0, 1'b0, img);
    chk("pin_chain_after_rst", 32'(chain), 32'h000817EA);

    // Randomised loads.
    for (int n = 0; n < 8; n++) begin
      full_load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), img);
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
